// File: rtl/score_display_controller.sv
// rtl/score_display_controller.sv - BCD score adder with a six-digit glyph overlay
// Define SCORE_SATURATE_EN to clamp at 999999 instead of wrapping modulo 1000000.
module score_display_controller #(
   parameter int         SX    = 48,
   parameter int         SY    = 40,
   parameter logic [2:0] COLOR = 3'b111
) (
   input  logic        pclk,
   input  logic        rst_n,
   input  logic [9:0]  pixel_x,
   input  logic [9:0]  pixel_y,
   input  logic        frame_tick,
   input  logic        add_valid,
   input  logic [7:0]  add_bcd,
   output logic        add_ready,
   input  logic        clear,
   output logic [7:0]  rom_addr,
   input  logic [7:0]  rom_data,
   output logic [23:0] score,
   output logic [2:0]  rgb,
   output logic        on
);
   localparam logic [9:0] SX_V = SX[9:0];
   localparam logic [9:0] SY_V = SY[9:0];

   typedef enum logic {IDLE, ADD} state_t;

   state_t      state;
   logic [7:0]  operand;
   logic [2:0]  idx;
   logic        carry;
   logic [23:0] disp_score;
   logic        pending;

   logic [3:0]  cur_digit;
   logic [3:0]  opd_digit;
   logic [3:0]  new_digit;
   logic [4:0]  sum;
   logic [4:0]  sum_adj;
   logic        carry_out;
   logic [23:0] score_upd;

   // One decimal digit per cycle; idx selects which digit of score is updated.
   always_comb begin
      case (idx)
         3'd0:    cur_digit = score[3:0];
         3'd1:    cur_digit = score[7:4];
         3'd2:    cur_digit = score[11:8];
         3'd3:    cur_digit = score[15:12];
         3'd4:    cur_digit = score[19:16];
         default: cur_digit = score[23:20];
      endcase
      case (idx)
         3'd0:    opd_digit = operand[3:0];
         3'd1:    opd_digit = operand[7:4];
         default: opd_digit = 4'd0;
      endcase
      sum       = {1'b0, cur_digit} + {1'b0, opd_digit} + {4'd0, carry};
      sum_adj   = sum - 5'd10;
      carry_out = (sum > 5'd9);
      new_digit = carry_out ? sum_adj[3:0] : sum[3:0];
      score_upd = score;
      case (idx)
         3'd0:    score_upd[3:0]   = new_digit;
         3'd1:    score_upd[7:4]   = new_digit;
         3'd2:    score_upd[11:8]  = new_digit;
         3'd3:    score_upd[15:12] = new_digit;
         3'd4:    score_upd[19:16] = new_digit;
         default: score_upd[23:20] = new_digit;
      endcase
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         add_ready <= 1'b1;
         score     <= 24'd0;
         operand   <= 8'd0;
         idx       <= 3'd0;
         carry     <= 1'b0;
      end else if (clear) begin
         state     <= IDLE;
         add_ready <= 1'b1;
         score     <= 24'd0;
         idx       <= 3'd0;
         carry     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (add_valid) begin
                  operand   <= add_bcd;
                  idx       <= 3'd0;
                  carry     <= 1'b0;
                  state     <= ADD;
                  add_ready <= 1'b0;
               end
            end
            ADD: begin
               carry <= carry_out;
               idx   <= idx + 3'd1;
               if (idx == 3'd5) begin
                  state     <= IDLE;
                  add_ready <= 1'b1;
`ifdef SCORE_SATURATE_EN
                  score     <= carry_out ? 24'h999999 : score_upd;
`else
                  score     <= score_upd;
`endif
               end else begin
                  score <= score_upd;
               end
            end
            default: begin
               state     <= IDLE;
               add_ready <= 1'b1;
            end
         endcase
      end
   end

   // A frame tick seen mid-add is remembered and honoured on the first idle cycle.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         disp_score <= 24'd0;
         pending    <= 1'b0;
      end else if (state == IDLE && (frame_tick || pending)) begin
         disp_score <= score;
         pending    <= 1'b0;
      end else if (frame_tick) begin
         pending <= 1'b1;
      end
   end

   logic [9:0] dx;
   logic [9:0] dy;
   logic       in_win;
   logic [3:0] glyph_digit;

   always_comb begin
      dx     = pixel_x - SX_V;
      dy     = pixel_y - SY_V;
      in_win = (pixel_x >= SX_V) && (dx <= 10'd47) && (pixel_y >= SY_V) && (dy <= 10'd12);
      case (dx[5:3])
         3'd0:    glyph_digit = disp_score[23:20];
         3'd1:    glyph_digit = disp_score[19:16];
         3'd2:    glyph_digit = disp_score[15:12];
         3'd3:    glyph_digit = disp_score[11:8];
         3'd4:    glyph_digit = disp_score[7:4];
         3'd5:    glyph_digit = disp_score[3:0];
         default: glyph_digit = 4'd0;
      endcase
   end

   logic [2:0] col_d1;
   logic [2:0] col_d2;
   logic       in_d1;
   logic       in_d2;

   // Address, ROM read and colour each take one edge: fixed three-edge latency.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         rom_addr <= 8'd0;
         col_d1   <= 3'd0;
         col_d2   <= 3'd0;
         in_d1    <= 1'b0;
         in_d2    <= 1'b0;
         on       <= 1'b0;
         rgb      <= 3'b000;
      end else begin
         rom_addr <= in_win ? {glyph_digit, dy[3:0]} : 8'd0;
         col_d1   <= dx[2:0];
         in_d1    <= in_win;
         col_d2   <= col_d1;
         in_d2    <= in_d1;
         on       <= in_d2;
         rgb      <= (in_d2 && rom_data[3'd7 - col_d2]) ? COLOR : 3'b000;
      end
   end

endmodule

// File: tb/tb_score_display_controller.sv
// tb/tb_score_display_controller.sv - table/scoreboard bench for score_display_controller
module tb_score_display_controller;
   localparam int         SX    = 48;
   localparam int         SY    = 40;
   localparam logic [2:0] COLOR = 3'b111;
   localparam int         NADD  = 6;
   localparam int         NPIX  = 10;

   logic        pclk = 1'b0;
   logic        rst_n;
   logic [9:0]  pixel_x;
   logic [9:0]  pixel_y;
   logic        frame_tick;
   logic        add_valid;
   logic [7:0]  add_bcd;
   logic        add_ready;
   logic        clear;
   logic [7:0]  rom_addr;
   logic [7:0]  rom_data;
   logic [23:0] score;
   logic [2:0]  rgb;
   logic        on;

   always #5 pclk = ~pclk;

   score_display_controller #(.SX(SX), .SY(SY), .COLOR(COLOR)) dut (
      .pclk(pclk), .rst_n(rst_n), .pixel_x(pixel_x), .pixel_y(pixel_y),
      .frame_tick(frame_tick), .add_valid(add_valid), .add_bcd(add_bcd),
      .add_ready(add_ready), .clear(clear), .rom_addr(rom_addr),
      .rom_data(rom_data), .score(score), .rgb(rgb), .on(on)
   );

   function automatic logic [7:0] rom_fn(input logic [7:0] a);
      if (a == 8'h33) return 8'h80;
      return a ^ 8'hB3;
   endfunction

   always @(posedge pclk) rom_data <= rom_fn(rom_addr);

   typedef struct { logic [7:0] opd; logic [23:0] exp; } add_vec_t;
   typedef struct { logic [9:0] px; logic [9:0] py; logic [7:0] addr; logic on; logic [2:0] col; } pix_vec_t;
   typedef struct { logic [7:0] addr; logic on; logic [2:0] rgb; } pix_exp_t;

   int          errors = 0;
   int          checks = 0;
   logic [23:0] sb_q[$];
   logic [7:0]  addr_q[$];
   pix_exp_t    pix_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic do_add(input logic [7:0] opd, input logic [23:0] exp, input bit chk);
      int          n;
      logic [23:0] want;
      n = 0;
      while (!add_ready && n < 20) begin
         tick();
         n++;
      end
      if (chk || !add_ready) check("ready_before_add", 32'(add_ready), 32'd1);
      add_valid = 1'b1;
      add_bcd   = opd;
      sb_q.push_back(exp);
      tick();
      add_valid = 1'b0;
      n = 0;
      while (!add_ready && n < 20) begin
         n++;
         tick();
      end
      want = sb_q.pop_front();
      if (chk || !add_ready) begin
         check("busy_cycles", 32'(n), 32'd6);
         check("score_after_add", 32'(score), 32'(want));
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      add_vec_t av[NADD];
      pix_vec_t pv[NPIX];
      pix_exp_t e;
      pix_exp_t e2;
      logic [7:0] r;
      int n;

      av[0] = '{8'h25, 24'h000025};
      av[1] = '{8'h70, 24'h000095};
      av[2] = '{8'h07, 24'h000102};
      av[3] = '{8'h99, 24'h000201};
      av[4] = '{8'h98, 24'h000299};
      av[5] = '{8'h01, 24'h000300};

      pv[0] = '{10'd88, 10'd43, 8'h33, 1'b1, 3'd0};
      pv[1] = '{10'd48, 10'd40, 8'h00, 1'b1, 3'd0};
      pv[2] = '{10'd96, 10'd40, 8'h00, 1'b0, 3'd0};
      pv[3] = '{10'd95, 10'd52, 8'h3C, 1'b1, 3'd7};
      pv[4] = '{10'd47, 10'd45, 8'h00, 1'b0, 3'd0};
      pv[5] = '{10'd60, 10'd53, 8'h00, 1'b0, 3'd0};
      pv[6] = '{10'd64, 10'd39, 8'h00, 1'b0, 3'd0};
      pv[7] = '{10'd74, 10'd44, 8'h14, 1'b1, 3'd2};
      pv[8] = '{10'd80, 10'd50, 8'h2A, 1'b1, 3'd0};
      pv[9] = '{10'd55, 10'd46, 8'h06, 1'b1, 3'd7};

      rst_n = 1'b0; clear = 1'b0; add_valid = 1'b0; add_bcd = 8'h00;
      frame_tick = 1'b0; pixel_x = 10'd0; pixel_y = 10'd0;
      repeat (3) tick();
      check("rst_score", 32'(score), 32'h0);
      check("rst_ready", 32'(add_ready), 32'd1);
      check("rst_rom_addr", 32'(rom_addr), 32'h0);
      check("rst_rgb", 32'(rgb), 32'h0);
      check("rst_on", 32'(on), 32'h0);
      rst_n = 1'b1;
      tick();
      check("ready_after_release", 32'(add_ready), 32'd1);

      clear = 1'b1; tick(); clear = 1'b0;
      for (int i = 0; i < NADD; i++) do_add(av[i].opd, av[i].exp, 1'b1);

      // clear on the third add cycle with add_valid held high
      add_valid = 1'b1; add_bcd = 8'h10;
      tick(); tick(); tick();
      clear = 1'b1;
      tick();
      check("clear_score", 32'(score), 32'h0);
      check("clear_idle", 32'(add_ready), 32'd1);
      tick();
      check("clear_blocks_handshake", 32'(add_ready), 32'd1);
      clear = 1'b0; add_valid = 1'b0;
      tick();
      check("clear_no_add", 32'(add_ready), 32'd1);
      check("clear_score_held", 32'(score), 32'h0);

      do_add(8'h99, 24'h000099, 1'b1);
      do_add(8'h24, 24'h000123, 1'b1);
      frame_tick = 1'b1; tick(); frame_tick = 1'b0;

      for (int i = 0; i < NPIX + 2; i++) begin
         if (i < NPIX) begin
            pixel_x = pv[i].px; pixel_y = pv[i].py;
            r = rom_fn(pv[i].addr);
            e = '{pv[i].addr, pv[i].on, (pv[i].on && r[3'd7 - pv[i].col]) ? COLOR : 3'b000};
         end else begin
            pixel_x = 10'd0; pixel_y = 10'd0;
            e = '{8'h00, 1'b0, 3'b000};
         end
         addr_q.push_back(e.addr);
         pix_q.push_back(e);
         tick();
         check("rom_addr", 32'(rom_addr), 32'(addr_q.pop_front()));
         if (pix_q.size() == 3) begin
            e2 = pix_q.pop_front();
            check("pix_on", 32'(on), 32'(e2.on));
            check("pix_rgb", 32'(rgb), 32'(e2.rgb));
         end
      end

      // frame tick during an add is deferred to the first idle cycle
      pixel_x = 10'd88; pixel_y = 10'd40;
      tick(); tick();
      check("disp_before_add", 32'(rom_addr), 32'h30);
      add_valid = 1'b1; add_bcd = 8'h05; tick(); add_valid = 1'b0;
      tick();
      frame_tick = 1'b1; tick(); frame_tick = 1'b0;
      n = 0;
      while (!add_ready && n < 20) begin
         check("disp_frozen", 32'(rom_addr), 32'h30);
         n++;
         tick();
      end
      check("ready_after_deferred", 32'(add_ready), 32'd1);
      check("score_128", 32'(score), 32'h000128);
      check("disp_held_at_done", 32'(rom_addr), 32'h30);
      tick();
      check("disp_old_at_load_edge", 32'(rom_addr), 32'h30);
      tick();
      check("disp_loaded", 32'(rom_addr), 32'h80);
      do_add(8'h01, 24'h000129, 1'b1);
      tick(); tick();
      check("single_load", 32'(rom_addr), 32'h80);

      // asynchronous reset in the middle of an add
      add_valid = 1'b1; add_bcd = 8'h50; tick(); add_valid = 1'b0;
      tick(); tick();
      rst_n = 1'b0;
      #1;
      check("mid_rst_score", 32'(score), 32'h0);
      check("mid_rst_ready", 32'(add_ready), 32'd1);
      check("mid_rst_rom_addr", 32'(rom_addr), 32'h0);
      check("mid_rst_on", 32'(on), 32'h0);
      check("mid_rst_rgb", 32'(rgb), 32'h0);
      tick();
      rst_n = 1'b1;
      repeat (8) tick();
      check("post_rst_score", 32'(score), 32'h0);
      check("post_rst_ready", 32'(add_ready), 32'd1);
      check("post_rst_on", 32'(on), 32'd1);

      for (int i = 0; i < 10100; i++) do_add(8'h99, 24'h000000, 1'b0);
      check("bulk_999900", 32'(score), 32'h999900);
      do_add(8'h90, 24'h999990, 1'b1);
`ifdef SCORE_SATURATE_EN
      do_add(8'h15, 24'h999999, 1'b1);
      do_add(8'h01, 24'h999999, 1'b1);
`else
      do_add(8'h15, 24'h000005, 1'b1);
      do_add(8'h01, 24'h000006, 1'b1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
